// File: rtl/contador_bcd_nd_pkg.sv
// contador_pkg: shared BCD digit type and constants
// for the N-digit up/down BCD counter.
package contador_pkg;

  localparam int BCD_MAX = 9;
  localparam int BCD_W   = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > bcd_t'(BCD_MAX)) ? bcd_t'(BCD_MAX) : d;
  endfunction

endpackage

// File: rtl/contador_bcd_nd_if.sv
// contador_bcd_nd_if: request/load bundle and count outputs
// of contador_bcd_nd, master drives requests, slave counts.
interface contador_bcd_nd_if #(
  parameter int N_DIG = 4
);

  logic               en;
  logic               inc;
  logic               dec;
  logic               load;
  logic [4*N_DIG-1:0] dato;
  logic [4*N_DIG-1:0] cta;
  logic               tc;

  modport master (
    output en, inc, dec, load, dato,
    input  cta, tc
  );

  modport slave (
    input  en, inc, dec, load, dato,
    output cta, tc
  );

endinterface

// File: rtl/contador_bcd_nd_digito.sv
// digito_bcd: one registered BCD digit with ripple carry/borrow.
// Load path present only with CONTADOR_BCD_LOAD_EN.
module digito_bcd
  import contador_pkg::*;
(
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Inc,
  input  logic i_Dec,
  input  logic i_Load,
  input  bcd_t i_Dato,
  output bcd_t o_Dig,
  output logic o_Carry,
  output logic o_Borrow
);

  bcd_t dig_q;
  bcd_t dig_d;

  assign o_Carry  = i_Inc & (dig_q == bcd_t'(BCD_MAX));
  assign o_Borrow = i_Dec & (dig_q == '0);
  assign o_Dig    = dig_q;

`ifdef CONTADOR_BCD_LOAD_EN
  always_comb begin
    dig_d = dig_q;
    unique case (1'b1)
      i_Load:  dig_d = bcd_clamp(i_Dato);
      i_Inc:   dig_d = o_Carry ? '0 : dig_q + 1'b1;
      i_Dec:   dig_d = o_Borrow ? bcd_t'(BCD_MAX)
                                : dig_q - 1'b1;
      default: dig_d = dig_q;
    endcase
  end
`else
  logic unused_ld;
  assign unused_ld = i_Load ^ (^i_Dato);

  always_comb begin
    dig_d = dig_q;
    unique case (1'b1)
      i_Inc:   dig_d = o_Carry ? '0 : dig_q + 1'b1;
      i_Dec:   dig_d = o_Borrow ? bcd_t'(BCD_MAX)
                                : dig_q - 1'b1;
      default: dig_d = dig_q;
    endcase
  end
`endif

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) dig_q <= '0;
    else        dig_q <= dig_d;
  end

endmodule

// File: rtl/contador_bcd_nd.sv
// contador_bcd_nd: N_DIG-digit BCD up/down counter, wrap or saturate.
// Define CONTADOR_BCD_LOAD_EN to add the i_Load/i_Dato parallel load.
module contador_bcd_nd
  import contador_pkg::*;
#(
  parameter int N_DIG = 4,
  parameter int WRAP  = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_En,
  input  logic                   i_Inc,
  input  logic                   i_Dec,
`ifdef CONTADOR_BCD_LOAD_EN
  input  logic                   i_Load,
  input  logic [BCD_W*N_DIG-1:0] i_Dato,
`endif
  output logic [BCD_W*N_DIG-1:0] o_Cta,
  output logic                   o_Tc
);

  logic [N_DIG:0]   carry;
  logic [N_DIG:0]   borrow;
  logic [N_DIG-1:0] dig_max;
  logic [N_DIG-1:0] dig_min;
  logic             ld;
  logic [BCD_W*N_DIG-1:0] dato;
  logic             req_inc;
  logic             req_dec;
  logic             at_max;
  logic             at_min;
  logic             sat;
  logic             tc_d;
  logic             tc_q;

`ifdef CONTADOR_BCD_LOAD_EN
  assign ld   = i_Load;
  assign dato = i_Dato;
`else
  assign ld   = 1'b0;
  assign dato = '0;
`endif

  // load wins over everything; inc+dec together is a hold
  assign req_inc = ~ld & i_En & i_Inc & ~i_Dec;
  assign req_dec = ~ld & i_En & i_Dec & ~i_Inc;

  assign at_max = &dig_max;
  assign at_min = &dig_min;
  assign sat    = (WRAP == 0);

  assign carry[0]  = req_inc & ~(sat & at_max);
  assign borrow[0] = req_dec & ~(sat & at_min);

  assign tc_d = (req_inc & at_max) | (req_dec & at_min);

  for (genvar g = 0; g < N_DIG; g++) begin : g_dig
    digito_bcd u_dig (
      .i_Clk    (i_Clk),
      .i_Rst    (i_Rst),
      .i_Inc    (carry[g]),
      .i_Dec    (borrow[g]),
      .i_Load   (ld),
      .i_Dato   (dato[g*BCD_W +: BCD_W]),
      .o_Dig    (o_Cta[g*BCD_W +: BCD_W]),
      .o_Carry  (carry[g+1]),
      .o_Borrow (borrow[g+1])
    );

    assign dig_max[g] =
      (o_Cta[g*BCD_W +: BCD_W] == bcd_t'(BCD_MAX));
    assign dig_min[g] =
      (o_Cta[g*BCD_W +: BCD_W] == '0);
  end

  logic unused_top;
  assign unused_top = carry[N_DIG] ^ borrow[N_DIG];

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) tc_q <= 1'b0;
    else        tc_q <= tc_d;
  end

  assign o_Tc = tc_q;

endmodule

// File: tb/tb_contador_bcd_nd.sv
// tb_contador_bcd_nd: two 2-digit counters (wrap and saturate)
// driven in lockstep and checked against an integer model.
module tb_contador_bcd_nd;

  localparam int ND   = 2;
  localparam int MAXV = 99;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  contador_bcd_nd_if #(.N_DIG(ND)) bw ();
  contador_bcd_nd_if #(.N_DIG(ND)) bs ();

  contador_bcd_nd #(.N_DIG(ND), .WRAP(1)) u_wrap (
    .i_Clk  (clk),
    .i_Rst  (rst_n),
    .i_En   (bw.en),
    .i_Inc  (bw.inc),
    .i_Dec  (bw.dec),
`ifdef CONTADOR_BCD_LOAD_EN
    .i_Load (bw.load),
    .i_Dato (bw.dato),
`endif
    .o_Cta  (bw.cta),
    .o_Tc   (bw.tc)
  );

  contador_bcd_nd #(.N_DIG(ND), .WRAP(0)) u_sat (
    .i_Clk  (clk),
    .i_Rst  (rst_n),
    .i_En   (bs.en),
    .i_Inc  (bs.inc),
    .i_Dec  (bs.dec),
`ifdef CONTADOR_BCD_LOAD_EN
    .i_Load (bs.load),
    .i_Dato (bs.dato),
`endif
    .o_Cta  (bs.cta),
    .o_Tc   (bs.tc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int va = 0;
  int vs = 0;
  bit ta = 0;
  bit ts = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int clamp_val(input logic [7:0] d);
    int hi, lo;
    hi = (d[7:4] > 9) ? 9 : int'(d[7:4]);
    lo = (d[3:0] > 9) ? 9 : int'(d[3:0]);
    return hi * 10 + lo;
  endfunction

  task automatic mstep(inout int v, inout bit t, input bit wrap,
                       input bit en, input bit inc, input bit dec,
                       input bit ld, input logic [7:0] dato);
    if (ld) begin
      v = clamp_val(dato);
      t = 0;
    end else if (en && (inc != dec)) begin
      if (inc) begin
        t = (v == MAXV);
        v = (v == MAXV) ? (wrap ? 0 : MAXV) : v + 1;
      end else begin
        t = (v == 0);
        v = (v == 0) ? (wrap ? MAXV : 0) : v - 1;
      end
    end else begin
      t = 0;
    end
  endtask

  task automatic drive(input bit en, input bit inc, input bit dec,
                       input bit ld, input logic [7:0] dato);
    bw.en = en; bw.inc = inc; bw.dec = dec;
    bw.load = ld; bw.dato = dato;
    bs.en = en; bs.inc = inc; bs.dec = dec;
    bs.load = ld; bs.dato = dato;
  endtask

  task automatic step(input bit en, input bit inc, input bit dec,
                      input bit ld = 0, input logic [7:0] dato = 8'h00);
    bit l;
`ifdef CONTADOR_BCD_LOAD_EN
    l = ld;
`else
    l = 0;
`endif
    drive(en, inc, dec, ld, dato);
    @(posedge clk);
    mstep(va, ta, 1'b1, en, inc, dec, l, dato);
    mstep(vs, ts, 1'b0, en, inc, dec, l, dato);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    va = 0; vs = 0; ta = 0; ts = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (bw.cta !== 8'h00) begin
      n_fail++; $display("FAIL reset_cta_w: got %h exp 00", bw.cta);
    end
    n_chk++;
    if (bw.tc !== 1'b0) begin
      n_fail++; $display("FAIL reset_tc_w: got %b exp 0", bw.tc);
    end
    n_chk++;
    if (bs.cta !== 8'h00) begin
      n_fail++; $display("FAIL reset_cta_s: got %h exp 00", bs.cta);
    end
    n_chk++;
    if (bs.tc !== 1'b0) begin
      n_fail++; $display("FAIL reset_tc_s: got %b exp 0", bs.tc);
    end
  endtask

  task automatic test_inc_wrap();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0);
      n_chk++;
      if (bw.tc !== 1'b0 || bs.tc !== 1'b0) begin
        n_fail++;
        $display("FAIL inc12_tc: got %b/%b exp 0", bw.tc, bs.tc);
      end
    end
    n_chk++;
    if (bw.cta !== 8'h12 || bs.cta !== 8'h12) begin
      n_fail++;
      $display("FAIL inc12_cta: got %h/%h exp 12", bw.cta, bs.cta);
    end
    for (int i = 0; i < 87; i++) step(1, 1, 0);
    n_chk++;
    if (bw.cta !== 8'h99) begin
      n_fail++; $display("FAIL at99: got %h exp 99", bw.cta);
    end
    step(1, 1, 0);
    n_chk++;
    if (bw.cta !== 8'h00 || bw.tc !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap99: got %h tc %b exp 00 tc 1", bw.cta, bw.tc);
    end
    n_chk++;
    if (bs.cta !== 8'h99 || bs.tc !== 1'b1) begin
      n_fail++;
      $display("FAIL sat99: got %h tc %b exp 99 tc 1", bs.cta, bs.tc);
    end
    step(1, 0, 0);
    n_chk++;
    if (bw.tc !== 1'b0 || bs.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL tc_width: got %b/%b exp 0", bw.tc, bs.tc);
    end
  endtask

  task automatic test_sat_dec();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1);
      n_chk++;
      if (bs.cta !== 8'h00 || bs.tc !== 1'b1) begin
        n_fail++;
        $display("FAIL sat00_%0d: got %h tc %b exp 00 tc 1",
                 i, bs.cta, bs.tc);
      end
      n_chk++;
      if (bw.cta !== to_bcd(va) || bw.tc !== ta) begin
        n_fail++;
        $display("FAIL wrapdec_%0d: got %h tc %b exp %h tc %b",
                 i, bw.cta, bw.tc, to_bcd(va), ta);
      end
    end
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 0);
    step(1, 0, 1);
    n_chk++;
    if (bs.cta !== 8'h09 || bw.cta !== 8'h09) begin
      n_fail++;
      $display("FAIL borrow10: got %h/%h exp 09", bw.cta, bs.cta);
    end
  endtask

  task automatic test_both_hold();
    do_reset();
    for (int i = 0; i < 45; i++) step(1, 1, 0);
    step(1, 1, 1);
    n_chk++;
    if (bw.cta !== 8'h45 || bw.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL both_en: got %h tc %b exp 45 tc 0", bw.cta, bw.tc);
    end
    step(0, 1, 1);
    n_chk++;
    if (bw.cta !== 8'h45 || bs.cta !== 8'h45) begin
      n_fail++;
      $display("FAIL both_dis: got %h/%h exp 45", bw.cta, bs.cta);
    end
    step(0, 1, 0);
    n_chk++;
    if (bw.cta !== 8'h45 || bw.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL en_low: got %h tc %b exp 45 tc 0", bw.cta, bw.tc);
    end
  endtask

`ifdef CONTADOR_BCD_LOAD_EN
  task automatic test_load();
    do_reset();
    step(1, 1, 0, 1, 8'h3C);
    n_chk++;
    if (bw.cta !== 8'h39 || bw.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL load3c: got %h tc %b exp 39 tc 0", bw.cta, bw.tc);
    end
    step(1, 0, 1, 1, 8'hF0);
    n_chk++;
    if (bs.cta !== 8'h90 || bs.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL loadf0: got %h tc %b exp 90 tc 0", bs.cta, bs.tc);
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 57; i++) step(1, 1, 0);
    n_chk++;
    if (bw.cta !== 8'h57) begin
      n_fail++; $display("FAIL pre57: got %h exp 57", bw.cta);
    end
    drive(1, 1, 0, 0, 8'h00);
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bw.cta !== 8'h00 || bw.tc !== 1'b0 || bs.cta !== 8'h00) begin
      n_fail++;
      $display("FAIL async_rst: got %h/%h tc %b exp 00 tc 0",
               bw.cta, bs.cta, bw.tc);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (bw.cta !== 8'h00 || bs.cta !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_hold: got %h/%h exp 00", bw.cta, bs.cta);
    end
    @(negedge clk);
    rst_n = 1'b1;
    va = 0; vs = 0; ta = 0; ts = 0;
    step(1, 1, 0);
    n_chk++;
    if (bw.cta !== 8'h01 || bs.cta !== 8'h01) begin
      n_fail++;
      $display("FAIL post_rst: got %h/%h exp 01", bw.cta, bs.cta);
    end
  endtask

  task automatic test_random();
    bit en, inc, dec, ld;
    logic [7:0] dato;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      inc  = (i < 200) ? ($urandom_range(0, 3) != 0)
                       : ($urandom_range(0, 3) == 0);
      dec  = $urandom_range(0, 1);
      ld   = ($urandom_range(0, 15) == 0);
      dato = 8'($urandom);
      step(en, inc, dec, ld, dato);
      n_chk++;
      if (bw.cta !== to_bcd(va) || bw.tc !== ta) begin
        n_fail++;
        $display("FAIL rnd_w_%0d: got %h tc %b exp %h tc %b",
                 i, bw.cta, bw.tc, to_bcd(va), ta);
      end
      n_chk++;
      if (bs.cta !== to_bcd(vs) || bs.tc !== ts) begin
        n_fail++;
        $display("FAIL rnd_s_%0d: got %h tc %b exp %h tc %b",
                 i, bs.cta, bs.tc, to_bcd(vs), ts);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, 0, 8'h00);
    #2;
    test_reset();
    test_inc_wrap();
    test_sat_dec();
    test_both_hold();
`ifdef CONTADOR_BCD_LOAD_EN
    test_load();
`endif
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
